// File: rtl/binarization_threshold_ctrl.sv
// Per-frame mean-luma threshold generator for a binarization stage.
// Sums valid luma, divides by pixel count after frame end, applies a signed offset, and loads at frame start.
module binarization_threshold_ctrl #(
  parameter int         SUM_W  = 30,
  parameter int         CNT_W  = 22,
  parameter logic [7:0] DEF_TH = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  input  logic       manual_en,
  input  logic [7:0] manual_threshold,
  input  logic [7:0] threshold_offset,
  output logic [7:0] Binary_Threshold,
  output logic       thresh_update,
  output logic       busy
);

  // state   | meaning
  // IDLE    | waiting for a frame end with pixels to average
  // DIV     | restoring divide, one quotient bit per cycle
  // ADJ     | add offset and saturate into pending value
  // HOLD    | pending value ready, applied at next frame start
  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_ADJ, ST_HOLD} state_t;

  localparam int ITER_W = $clog2(SUM_W + 1);

  state_t             state_q, state_d;
  logic               vs_q, vs_d;
  logic               armed_q, armed_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   quo_q, quo_d;
  logic [CNT_W:0]     rem_q, rem_d;
  logic [CNT_W-1:0]   den_q, den_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [7:0]         pending_q, pending_d;
  logic [7:0]         thr_q, thr_d;
  logic               upd_q, upd_d;

  logic               frame_start, frame_end, pix_valid, div_start, load_thr;
  logic [CNT_W:0]     rem_shift, rem_diff;
  logic               rem_ge;
  logic signed [9:0]  adj_sum;

  assign frame_start = per_frame_vsync & ~vs_q;
  assign frame_end   = ~per_frame_vsync & vs_q;
  assign pix_valid   = per_frame_vsync & per_frame_href & per_frame_clken & armed_q;
  assign div_start   = (state_q == ST_IDLE) && frame_end && (cnt_q != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (div_start)       state_d = ST_DIV;
      ST_DIV:  if (iter_q == '0)    state_d = ST_ADJ;
      ST_ADJ:                       state_d = ST_HOLD;
      ST_HOLD: if (frame_start)     state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Output logic; a load happens only at frame start so the threshold is stable within a frame
  always_comb begin
    busy     = (state_q == ST_DIV) || (state_q == ST_ADJ);
    load_thr = frame_start && (manual_en || (state_q == ST_HOLD));
  end

  // Shifted-out remainder bit forces a subtract even when the low bits compare smaller
  assign rem_shift = {rem_q[CNT_W-1:0], quo_q[SUM_W-1]};
  assign rem_diff  = rem_shift - {1'b0, den_q};
  assign rem_ge    = rem_q[CNT_W] | (rem_shift >= {1'b0, den_q});
  assign adj_sum   = $signed({2'b00, quo_q[7:0]}) + $signed({{2{threshold_offset[7]}}, threshold_offset});

  always_comb begin
    vs_d      = per_frame_vsync;
    armed_d   = armed_q | frame_start;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    den_d     = den_q;
    iter_d    = iter_q;
    pending_d = pending_q;
    thr_d     = thr_q;
    upd_d     = load_thr;

    if (frame_start) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (pix_valid) begin
      sum_d = sum_q + SUM_W'(per_img_Y);
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (div_start) begin
      quo_d  = sum_q;
      rem_d  = '0;
      den_d  = cnt_q;
      iter_d = ITER_W'(SUM_W - 1);
    end else if (state_q == ST_DIV) begin
      rem_d  = rem_ge ? rem_diff : rem_shift;
      quo_d  = {quo_q[SUM_W-2:0], rem_ge};
      iter_d = iter_q - ITER_W'(1);
    end

    if (state_q == ST_ADJ) begin
      if (adj_sum[9])      pending_d = 8'd0;
      else if (adj_sum[8]) pending_d = 8'd255;
      else                 pending_d = adj_sum[7:0];
    end

    if (load_thr) thr_d = manual_en ? manual_threshold : pending_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b1;
      armed_q   <= 1'b0;
      sum_q     <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      iter_q    <= '0;
      pending_q <= DEF_TH;
      thr_q     <= DEF_TH;
      upd_q     <= 1'b0;
    end else begin
      vs_q      <= vs_d;
      armed_q   <= armed_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      den_q     <= den_d;
      iter_q    <= iter_d;
      pending_q <= pending_d;
      thr_q     <= thr_d;
      upd_q     <= upd_d;
    end
  end

  assign Binary_Threshold = thr_q;
  assign thresh_update    = upd_q;

endmodule
